router_1xn_switch: RTL and testbench

Parametrised successor to the 1x3 router top level: one byte-serial packet input routed to N_OUT output channels, each with its own FIFO. Packets are `{payload_len, addr}` header, payload bytes, then a parity byte. New behaviour:
- generic data width, channel count and FIFO depth;
- invalid-address packet drop;
- payload-length checking;
- per-channel idle-read timeout flush that also aborts an in-flight packet.

---
 rtl/router_1xn_switch.sv | 201 ++++++++++++++++++++
 tb/tb_router_1xn_switch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_1xn_switch.sv
//==============================================================================
// router_1xn_switch - 1:N byte-serial packet router with per-channel FIFOs. Rev 1.0
//==============================================================================
`default_nettype none

module router_1xn_switch #(
  parameter int DW      = 8,
  parameter int N_OUT   = 3,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pkt_vld,
  input  logic [DW-1:0]       d_in,
  input  logic [N_OUT-1:0]    rd_en,
  output logic                busy,
  output logic                err,
  output logic                drop,
  output logic [N_OUT-1:0]    vld_out,
  output logic [N_OUT*DW-1:0] d_out
);

  localparam int AW    = ($clog2(N_OUT) > 1) ? $clog2(N_OUT) : 1;
  localparam int LEN_W = DW - AW;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]    C_FULL    = CW'(DEPTH);
  localparam logic [TW-1:0]    C_TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]      C_NOUT    = (AW + 1)'(N_OUT);
  localparam logic [LEN_W:0]   C_BCNT_1  = (LEN_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_WAIT      = 3'd2,
    S_LOAD_HDR  = 3'd3,
    S_LOAD_DATA = 3'd4,
    S_FULL      = 3'd5,
    S_DROP      = 3'd6
  } state_t;

  state_t           r_state, w_next;
  logic [DW-1:0]    r_hdr, r_par;
  logic [LEN_W:0]   r_bcnt;
  logic             r_err, r_drop;
  logic [AW-1:0]    w_addr, w_dst;
  logic [LEN_W-1:0] w_len;
  logic             w_addr_ok;
  logic [N_OUT-1:0] w_full, w_empty, w_flush;
  logic             w_dst_full, w_dst_empty, w_dst_flush;
  logic             w_wr, w_cap, w_pay, w_chk;
  logic [DW-1:0]    w_wdata;

  assign w_addr      = r_hdr[AW-1:0];
  assign w_len       = r_hdr[DW-1:AW];
  assign w_addr_ok   = ({1'b0, w_addr} < C_NOUT);
  assign w_dst       = w_addr_ok ? w_addr : '0;
  assign w_dst_full  = w_full[w_dst];
  assign w_dst_empty = w_empty[w_dst];
  assign w_dst_flush = w_flush[w_dst];

  // busy drops in the FULL cycle that takes the held byte, so "busy low before
  // an edge" always means the byte on d_in is consumed at that edge.
  assign busy = (r_state == S_DECODE) | (r_state == S_WAIT) | (r_state == S_LOAD_HDR) |
                (((r_state == S_LOAD_DATA) | (r_state == S_FULL)) & w_dst_full);
  assign err  = r_err;
  assign drop = r_drop;

  always_comb begin
    w_next  = r_state;
    w_wr    = 1'b0;
    w_wdata = d_in;
    w_cap   = 1'b0;
    w_pay   = 1'b0;
    w_chk   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pkt_vld) begin
          w_cap  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!w_addr_ok)       w_next = S_DROP;
        else if (w_dst_empty) w_next = S_LOAD_HDR;
        else                  w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_dst_empty) w_next = S_LOAD_HDR;
      end
      S_LOAD_HDR: begin
        if (w_dst_flush) begin
          w_next = S_DROP;
        end else begin
          w_wr    = 1'b1;
          w_wdata = r_hdr;
          w_next  = S_LOAD_DATA;
        end
      end
      S_LOAD_DATA, S_FULL: begin
        if (w_dst_flush) begin
          w_next = S_DROP;
        end else if (w_dst_full) begin
          w_next = S_FULL;
        end else begin
          w_wr = 1'b1;
          if (pkt_vld) begin
            w_pay  = 1'b1;
            w_next = S_LOAD_DATA;
          end else begin
            w_chk  = 1'b1;
            w_next = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (!pkt_vld) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hdr   <= '0;
      r_par   <= '0;
      r_bcnt  <= '0;
      r_err   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drop  <= (w_next == S_DROP) && (r_state != S_DROP);
      if (w_cap) begin
        r_hdr  <= d_in;
        r_par  <= d_in;
        r_bcnt <= '0;
        r_err  <= 1'b0;
      end else if (w_pay) begin
        r_par <= r_par ^ d_in;
        if (r_bcnt != '1) r_bcnt <= r_bcnt + C_BCNT_1;
      end else if (w_chk) begin
        r_err <= (r_par != d_in) | (r_bcnt != {1'b0, w_len});
      end
    end
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_ch
    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_to;
    logic [DW-1:0] r_dout;
    logic          w_wr_i, w_rd_i;

    assign w_wr_i       = w_wr & (w_dst == AW'(gi));
    assign w_rd_i       = rd_en[gi] & (r_cnt != '0);
    assign w_full[gi]   = (r_cnt == C_FULL);
    assign w_empty[gi]  = (r_cnt == '0);
    assign w_flush[gi]  = (r_cnt != '0) & ~rd_en[gi] & (r_to == C_TO_LAST);
    assign vld_out[gi]  = (r_cnt != '0);
    assign d_out[gi*DW +: DW] = r_dout;

    always_ff @(posedge clk) begin
      if (w_wr_i) r_mem[r_wp] <= w_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wp   <= '0;
        r_rp   <= '0;
        r_cnt  <= '0;
        r_to   <= '0;
        r_dout <= '0;
      end else if (w_flush[gi]) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        r_to  <= '0;
      end else begin
        if (w_wr_i) r_wp <= r_wp + PW'(1);
        if (w_rd_i) begin
          r_dout <= r_mem[r_rp];
          r_rp   <= r_rp + PW'(1);
        end
        case ({w_wr_i, w_rd_i})
          2'b10:   r_cnt <= r_cnt + CW'(1);
          2'b01:   r_cnt <= r_cnt - CW'(1);
          default: r_cnt <= r_cnt;
        endcase
        if (rd_en[gi] || (r_cnt == '0)) r_to <= '0;
        else                            r_to <= r_to + TW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_router_1xn_switch.sv
//==============================================================================
// tb_router_1xn_switch - randomized packets checked against per-channel word queues. Rev 1.0
//==============================================================================
`default_nettype none

module tb_router_1xn_switch;

  localparam int DW = 8, N_OUT = 3, DEPTH = 16, TIMEOUT = 30;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                pkt_vld = 1'b0;
  logic [DW-1:0]       d_in = '0;
  logic [N_OUT-1:0]    rd_en = '0;
  logic                busy, err, drop;
  logic [N_OUT-1:0]    vld_out;
  logic [N_OUT*DW-1:0] d_out;

  router_1xn_switch #(.DW(DW), .N_OUT(N_OUT), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pkt_vld(pkt_vld), .d_in(d_in), .rd_en(rd_en),
    .busy(busy), .err(err), .drop(drop), .vld_out(vld_out), .d_out(d_out)
  );

  always #5 clk = ~clk;

  int         n_vec = 0, n_err = 0, busy_waits = 0;
  logic [7:0] exp_q [N_OUT][$];
  logic [7:0] pk [$];
  logic [7:0] pk_par;
  bit         exp_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until an edge where busy is low consumes it.
  task automatic put(input logic v, input logic [7:0] d);
    int g = 0;
    pkt_vld = v;
    d_in    = d;
    while (busy && g < 200) begin tick(); g++; busy_waits++; end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL put_wait: busy=%0b required 0", busy); end
    tick();
  endtask

  // Expected packet: every word a valid-address packet writes lands in exp_q[addr].
  task automatic make_pkt(input int addr, input int len, input int npay, input bit corrupt);
    logic [7:0] p;
    pk.delete();
    pk.push_back({len[5:0], addr[1:0]});
    for (int i = 0; i < npay; i++) pk.push_back(8'($urandom));
    p = 8'h00;
    foreach (pk[i]) p = p ^ pk[i];
    pk_par  = corrupt ? (p ^ 8'h01) : p;
    exp_err = (addr < N_OUT) && (corrupt || (npay != len));
    if (addr < N_OUT) begin
      foreach (pk[i]) exp_q[addr].push_back(pk[i]);
      exp_q[addr].push_back(pk_par);
    end
  endtask

  task automatic send_from(input int start);
    for (int i = start; i < pk.size(); i++) put(1'b1, pk[i]);
    put(1'b0, pk_par);
  endtask

  task automatic read_chk(input int ch, input int n);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      rd_en[ch] = 1'b1;
      tick();
      e = exp_q[ch].pop_front();
      n_vec++;
      if (d_out[ch*DW +: DW] !== e) begin
        n_err++;
        $display("FAIL read ch%0d word%0d: got %02h required %02h", ch, k, d_out[ch*DW +: DW], e);
      end
    end
    rd_en[ch] = 1'b0;
    n_vec++;
    if (vld_out[ch] !== (exp_q[ch].size() != 0)) begin
      n_err++;
      $display("FAIL vld_after_read ch%0d: got %0b required %0b", ch, vld_out[ch], exp_q[ch].size() != 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_vec++;
    if ({busy, err, drop} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b required 000", {busy, err, drop}); end
    n_vec++;
    if (vld_out !== '0) begin n_err++; $display("FAIL reset_vld: got %b required 0", vld_out); end
    n_vec++;
    if (d_out !== '0) begin n_err++; $display("FAIL reset_dout: got %h required 0", d_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    make_pkt(2, 14, 14, 1'b0);
    put(1'b1, pk[0]);
    pkt_vld = 1'b1;
    d_in    = pk[1];
    n_vec++;
    if ({busy, vld_out[2]} !== 2'b10) begin n_err++; $display("FAIL basic_E0: busy,vld=%b required 10", {busy, vld_out[2]}); end
    tick();
    n_vec++;
    if (vld_out[2] !== 1'b0) begin n_err++; $display("FAIL basic_E1: vld=%0b required 0", vld_out[2]); end
    tick();
    n_vec++;
    if ({busy, vld_out[2]} !== 2'b01) begin n_err++; $display("FAIL basic_E2: busy,vld=%b required 01", {busy, vld_out[2]}); end
    busy_waits = 0;
    send_from(1);
    n_vec++;
    if (busy_waits != 0) begin n_err++; $display("FAIL basic_stall: busy cycles=%0d required 0", busy_waits); end
    n_vec++;
    if (err !== exp_err) begin n_err++; $display("FAIL basic_err: got %0b required %0b", err, exp_err); end
    read_chk(2, 16);
  endtask

  task automatic test_errors();
    make_pkt(2, 14, 14, 1'b1);
    send_from(0);
    n_vec++;
    if (err !== exp_err) begin n_err++; $display("FAIL parity_err: got %0b required %0b", err, exp_err); end
    read_chk(2, 16);
    n_vec++;
    if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %0b required 1", err); end
    make_pkt(0, 3, 4, 1'b0);
    put(1'b1, pk[0]);
    n_vec++;
    if (err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %0b required 0", err); end
    send_from(1);
    n_vec++;
    if (err !== exp_err) begin n_err++; $display("FAIL len_err: got %0b required %0b", err, exp_err); end
    read_chk(0, 6);
    make_pkt(1, 0, 0, 1'b0);
    send_from(0);
    n_vec++;
    if (err !== exp_err) begin n_err++; $display("FAIL len0_err: got %0b required %0b", err, exp_err); end
    read_chk(1, 2);
  endtask

  task automatic test_drop();
    make_pkt(3, 3, 3, 1'b0);
    put(1'b1, pk[0]);
    n_vec++;
    if ({busy, drop} !== 2'b10) begin n_err++; $display("FAIL drop_decode: busy,drop=%b required 10", {busy, drop}); end
    pkt_vld = 1'b1;
    d_in    = pk[1];
    tick();
    n_vec++;
    if ({busy, drop} !== 2'b01) begin n_err++; $display("FAIL drop_pulse: busy,drop=%b required 01", {busy, drop}); end
    put(1'b1, pk[1]);
    n_vec++;
    if (drop !== 1'b0) begin n_err++; $display("FAIL drop_width: drop=%0b required 0", drop); end
    send_from(2);
    n_vec++;
    if ({err, vld_out} !== 4'b0000) begin n_err++; $display("FAIL drop_nowrite: err,vld=%b required 0000", {err, vld_out}); end
  endtask

  task automatic test_full();
    int g = 0, cyc = 0;
    logic [7:0] e;
    make_pkt(0, 20, 20, 1'b0);
    fork
      send_from(0);
      begin
        while (!vld_out[0] && g < 50) begin tick(); g++; end
        while (!busy && cyc < 50) begin tick(); cyc++; end
        n_vec++;
        if (cyc != 15) begin n_err++; $display("FAIL full_entry: cycles=%0d required 15", cyc); end
        tick(); tick(); tick();
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL full_hold: busy=%0b required 1", busy); end
        for (int k = 0; k < 6; k++) begin
          rd_en[0] = 1'b1;
          tick();
          rd_en[0] = 1'b0;
          e = exp_q[0].pop_front();
          n_vec++;
          if (d_out[DW-1:0] !== e) begin n_err++; $display("FAIL full_read%0d: got %02h required %02h", k, d_out[DW-1:0], e); end
          tick();
        end
      end
    join
    n_vec++;
    if (err !== exp_err) begin n_err++; $display("FAIL full_err: got %0b required %0b", err, exp_err); end
    read_chk(0, 16);
  endtask

  task automatic test_timeout();
    int g = 0, cyc = 0, drops = 0;
    bit done = 0, dvld = 1;
    make_pkt(1, 2, 2, 1'b0);
    fork
      send_from(0);
      begin
        while (!vld_out[1] && g < 50) begin tick(); g++; end
        while (vld_out[1] && cyc < 60) begin tick(); cyc++; end
      end
    join
    exp_q[1].delete();
    n_vec++;
    if (cyc != TIMEOUT) begin n_err++; $display("FAIL timeout_flush: cycles=%0d required %0d", cyc, TIMEOUT); end
    make_pkt(1, 40, 40, 1'b0);
    g = 0;
    fork
      begin send_from(0); done = 1; end
      while (!done && g < 400) begin
        tick(); g++;
        if (drop) begin drops++; dvld = vld_out[1]; end
      end
    join
    exp_q[1].delete();
    n_vec++;
    if (drops != 1) begin n_err++; $display("FAIL abort_drop: pulses=%0d required 1", drops); end
    n_vec++;
    if (dvld !== 1'b0) begin n_err++; $display("FAIL abort_flush: vld=%0b required 0", dvld); end
    n_vec++;
    if ({err, vld_out} !== 4'b0000) begin n_err++; $display("FAIL abort_state: err,vld=%b required 0000", {err, vld_out}); end
  endtask

  task automatic test_reset_mid();
    make_pkt(0, 10, 10, 1'b0);
    for (int i = 0; i < 5; i++) put(1'b1, pk[i]);
    n_vec++;
    if (vld_out[0] !== 1'b1) begin n_err++; $display("FAIL midrst_pre: vld=%0b required 1", vld_out[0]); end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, err, drop, vld_out, d_out} !== '0) begin
      n_err++;
      $display("FAIL midrst_async: flags=%b vld=%b dout=%h required all 0", {busy, err, drop}, vld_out, d_out);
    end
    pkt_vld = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_q[0].delete();
    tick();
    make_pkt(0, 5, 5, 1'b0);
    send_from(0);
    n_vec++;
    if (err !== exp_err) begin n_err++; $display("FAIL midrst_err: got %0b required %0b", err, exp_err); end
    read_chk(0, 7);
  endtask

  task automatic test_random();
    int addr, len, mode, npay;
    for (int it = 0; it < 12; it++) begin
      addr = (it == 1) ? 3 : $urandom_range(0, 3);
      len  = (it == 0) ? 0 : $urandom_range(0, 13);
      mode = $urandom_range(0, 2);
      npay = (mode == 2) ? len + 1 : len;
      make_pkt(addr, len, npay, mode == 1);
      send_from(0);
      n_vec++;
      if (err !== exp_err) begin n_err++; $display("FAIL rand%0d_err: got %0b required %0b", it, err, exp_err); end
      if (addr < N_OUT) begin
        read_chk(addr, npay + 2);
      end else begin
        n_vec++;
        if (vld_out !== '0) begin n_err++; $display("FAIL rand%0d_drop: vld=%b required 0", it, vld_out); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_drop();
    test_full();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
